// File: rtl/adder_scheduler.sv
// Round-robin scheduler sharing one external N-bit adder between NUM_REQ requesters.
// Define ADDER_SCHED_STATS_EN to add the saturating busy_cycles counter and its stats_clr input.
module adder_scheduler #(
   parameter int N       = 32,
   parameter int NUM_REQ = 4,
   parameter int ADD_LAT = 1,
   localparam int IDW    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*N-1:0] req_a,
   input  logic [NUM_REQ*N-1:0] req_b,
   output logic [N-1:0]         add_a,
   output logic [N-1:0]         add_b,
   input  logic [N:0]           add_sum,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [N:0]           rsp_sum,
   output logic [IDW-1:0]       rsp_id,
`ifdef ADDER_SCHED_STATS_EN
   output logic [31:0]          busy_cycles,
   input  logic                 stats_clr,
`endif
   output logic                 busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]     state_reg;
   logic [IDW-1:0] ptr_reg;
   logic [3:0]     cnt_reg;
   logic [N-1:0]   add_a_reg;
   logic [N-1:0]   add_b_reg;
   logic [N:0]     rsp_sum_reg;
   logic [IDW-1:0] rsp_id_reg;

   logic [IDW-1:0] win_idx;
   logic [IDW-1:0] ptr_next;
   logic [IDW:0]   cand;
   logic           win_found;
   logic           grant_en;
   logic [N-1:0]   a_arr [NUM_REQ];
   logic [N-1:0]   b_arr [NUM_REQ];

   // Search upward from ptr_reg with wrap; the first valid requester wins.
   always_comb begin
      win_idx   = ptr_reg;
      win_found = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_reg} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NUM_REQ))
            cand = cand - (IDW+1)'(NUM_REQ);
         if (!win_found && req_valid[cand[IDW-1:0]]) begin
            win_idx   = cand[IDW-1:0];
            win_found = 1'b1;
         end
      end
   end

   assign grant_en = (state_reg == IDLE) && win_found;
   assign ptr_next = (win_idx == IDW'(NUM_REQ-1)) ? '0 : win_idx + IDW'(1);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign a_arr[gi]     = req_a[gi*N +: N];
         assign b_arr[gi]     = req_b[gi*N +: N];
         // Gated by rst_n so no grant is offered while reset is held.
         assign req_ready[gi] = rst_n && grant_en && (win_idx == IDW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         ptr_reg     <= '0;
         cnt_reg     <= '0;
         add_a_reg   <= '0;
         add_b_reg   <= '0;
         rsp_sum_reg <= '0;
         rsp_id_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant_en) begin
                  add_a_reg  <= a_arr[win_idx];
                  add_b_reg  <= b_arr[win_idx];
                  rsp_id_reg <= win_idx;
                  cnt_reg    <= 4'(ADD_LAT);
                  ptr_reg    <= ptr_next;
                  state_reg  <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_reg != 4'd0) begin
                  cnt_reg <= cnt_reg - 4'd1;
               end else begin
                  rsp_sum_reg <= add_sum;
                  state_reg   <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign add_a     = add_a_reg;
   assign add_b     = add_b_reg;
   assign rsp_sum   = rsp_sum_reg;
   assign rsp_id    = rsp_id_reg;
   assign rsp_valid = (state_reg == RESP);
   assign busy      = (state_reg != IDLE);

`ifdef ADDER_SCHED_STATS_EN
   logic [31:0] busy_cycles_reg;

   // Clear wins over increment; the count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy_cycles_reg <= '0;
      else if (stats_clr)
         busy_cycles_reg <= '0;
      else if (busy && (busy_cycles_reg != 32'hFFFF_FFFF))
         busy_cycles_reg <= busy_cycles_reg + 32'd1;
   end

   assign busy_cycles = busy_cycles_reg;
`endif

endmodule

// File: tb/tb_adder_scheduler.sv
// Self-checking bench for adder_scheduler: directed test-plan steps followed by randomized
// operations, checked against a round-robin/arithmetic reference model.
module tb_adder_scheduler;

   localparam int N       = 32;
   localparam int NUM_REQ = 4;
   localparam int ADD_LAT = 1;
   localparam int IDW     = $clog2(NUM_REQ);

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NUM_REQ-1:0]   req_valid = '0;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ*N-1:0] req_a = '0;
   logic [NUM_REQ*N-1:0] req_b = '0;
   logic [N-1:0]         add_a;
   logic [N-1:0]         add_b;
   logic [N:0]           add_sum = '0;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b0;
   logic [N:0]           rsp_sum;
   logic [IDW-1:0]       rsp_id;
   logic                 busy;
`ifdef ADDER_SCHED_STATS_EN
   logic [31:0]          busy_cycles;
   logic                 stats_clr = 1'b0;
`endif

   adder_scheduler #(.N(N), .NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
`ifdef ADDER_SCHED_STATS_EN
      .busy_cycles(busy_cycles), .stats_clr(stats_clr),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Shared adder with one clock edge of latency.
   always @(posedge clk) add_sum <= {1'b0, add_a} + {1'b0, add_b};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;

   logic [N-1:0] op_a [NUM_REQ];
   logic [N-1:0] op_b [NUM_REQ];
   int m_ptr = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_winner(input logic [NUM_REQ-1:0] mask);
      for (int k = 0; k < NUM_REQ; k++)
         if (mask[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
      return -1;
   endfunction

   task automatic pack_ops();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_a[i*N +: N] = op_a[i];
         req_b[i*N +: N] = op_b[i];
      end
   endtask

   // Runs one operation from a negedge in IDLE back to a negedge in IDLE.
   task automatic run_op(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ-1:0] post,
                         input int stall, output int win, output int hs);
      logic [N:0] exp_sum;
      logic [N:0] held_sum;
      bit seen;
      pack_ops();
      req_valid = mask;
      rsp_ready = (stall == 0);
      win = exp_winner(mask);
      #1;
      check("grant_onehot", 64'(req_ready), 64'(1) << win);
      @(posedge clk); #1;
      hs = cyc;
      m_ptr = (win + 1) % NUM_REQ;
      exp_sum = {1'b0, op_a[win]} + {1'b0, op_b[win]};
      req_valid = post;
      #1;
      check("add_a_issued", 64'(add_a), 64'(op_a[win]));
      check("add_b_issued", 64'(add_b), 64'(op_b[win]));
      check("busy_in_wait", 64'(busy), 64'd1);
      check("no_ready_in_wait", 64'(req_ready), 64'd0);
      seen = 0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (rsp_valid) begin seen = 1; break; end
      end
      if (!seen) begin
         check("rsp_timeout", 64'd0, 64'd1);
         return;
      end
      check("rsp_latency", 64'(cyc - hs), 64'(ADD_LAT + 1));
      check("rsp_sum", 64'(rsp_sum), 64'(exp_sum));
      check("rsp_id", 64'(rsp_id), 64'(win));
      held_sum = rsp_sum;
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); @(negedge clk);
         check("stall_valid", 64'(rsp_valid), 64'd1);
         check("stall_sum", 64'(rsp_sum), 64'(held_sum));
         check("stall_id", 64'(rsp_id), 64'(win));
         check("stall_no_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      check("rsp_one_cycle", 64'(rsp_valid), 64'd0);
      check("idle_not_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      int win, hs, prev_hs;
      logic [NUM_REQ-1:0] cur, newb;

      for (int i = 0; i < NUM_REQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
      req_valid = '1;
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_add_a", 64'(add_a), 64'd0);
      check("rst_add_b", 64'(add_b), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_sum", 64'(rsp_sum), 64'd0);
      check("rst_rsp_id", 64'(rsp_id), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      req_valid = '0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      op_a[0] = 32'd1000; op_b[0] = 32'd1000;
      run_op(4'b0001, 4'b0000, 0, win, hs);
      op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'd1;
      run_op(4'b0100, 4'b0000, 0, win, hs);

      // Abort an operation mid-WAIT.
      op_a[1] = 32'd5; op_b[1] = 32'd6;
      pack_ops();
      req_valid = 4'b0010;
      @(posedge clk); @(negedge clk);
      check("inflight_add_a", 64'(add_a), 64'd5);
      op_a[0] = 32'd10; op_b[0] = 32'd20; op_a[3] = 32'd30; op_b[3] = 32'd40;
      pack_ops();
      req_valid = 4'b1001;
      rst_n = 1'b0;
      #1;
      check("abort_add_a", 64'(add_a), 64'd0);
      check("abort_add_b", 64'(add_b), 64'd0);
      check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_req_ready", 64'(req_ready), 64'd0);
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         check("abort_no_rsp", 64'(rsp_valid), 64'd0);
      end
      rst_n = 1'b1;
      m_ptr = 0;
      op_a[1] = 32'd77; op_b[1] = 32'd23;
      run_op(4'b1001, 4'b1010, 5, win, hs);
      check("after_abort_winner", 64'(win), 64'd0);
      run_op(4'b1010, 4'b1000, 0, win, hs);
      check("ptr_follow_winner", 64'(win), 64'd1);

      // Short reset so the round-robin sweep starts from requester 0.
      req_valid = '0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
      for (int i = 0; i < NUM_REQ; i++) begin op_a[i] = 32'(i); op_b[i] = 32'd1000; end
      prev_hs = 0;
      for (int r = 0; r < 5; r++) begin
         run_op(4'b1111, 4'b1111, 0, win, hs);
         check("rr_order", 64'(win), 64'(r % NUM_REQ));
         if (r > 0) check("rr_period", 64'(hs - prev_hs), 64'(ADD_LAT + 3));
         prev_hs = hs;
      end
      req_valid = '0;
      @(negedge clk);

`ifdef ADDER_SCHED_STATS_EN
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      for (int r = 0; r < 3; r++) run_op(4'b0001, 4'b0001, 0, win, hs);
      req_valid = '0;
      check("stats_busy_cycles", 64'(busy_cycles), 64'(3 * (ADD_LAT + 2)));
      stats_clr = 1'b1;
      @(posedge clk); #1;
      check("stats_clear", 64'(busy_cycles), 64'd0);
      stats_clr = 1'b0;
      @(negedge clk);
`endif

      // Randomized traffic; pending requesters keep their valid and operands.
      cur = '0;
      for (int it = 0; it < 30; it++) begin
         newb = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
         if ((cur | newb) == '0) newb[$urandom_range(0, NUM_REQ-1)] = 1'b1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (newb[i] && !cur[i]) begin
               op_a[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
               op_b[i] = 32'($urandom);
            end
         end
         cur = cur | newb;
         win = exp_winner(cur);
         run_op(cur, cur & ~(NUM_REQ'(1) << win), $urandom_range(0, 3), win, hs);
         cur = cur & ~(NUM_REQ'(1) << win);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
